// File: rtl/correlator_cmd_pkg.sv
// Shared definitions for the correlator command link: command codes, the
// transmitter state encoding and the byte-packing helper.
package correlator_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_RESET           = 4'd0,
        CMD_SET_SAMPLE_TIME = 4'd1,
        CMD_SET_ACTIVE_LINE = 4'd2,
        CMD_ENABLE_MODULES  = 4'd12,
        CMD_COMMIT          = 4'd13
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_RESET,
        ST_SEND_NIBBLE,
        ST_SEND_ENABLE,
        ST_SEND_COMMIT,
        ST_GAP
    } state_e;

    // Every byte on the link carries a 4-bit payload nibble above a 4-bit code.
    function automatic logic [7:0] make_byte(input logic [3:0] nibble, input logic [3:0] code);
        return {nibble, code};
    endfunction

endpackage

// File: rtl/correlator_cmd_tx_if.sv
// Host request handshake plus the byte stream towards the UART transmitter.
interface correlator_cmd_tx_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [63:0] req_value;
    logic        req_commit;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        cmd_error;

    // Host / UART side.
    modport master (
        output req_valid, req_cmd, req_value, req_commit, byte_ready,
        input  req_ready, byte_data, byte_valid, busy, cmd_error
    );

    // Command transmitter side.
    modport slave (
        input  req_valid, req_cmd, req_value, req_commit, byte_ready,
        output req_ready, byte_data, byte_valid, busy, cmd_error
    );

endinterface

// File: rtl/correlator_cmd_tx.sv
// Turns one host command request into the byte sequence understood by the
// correlator command receiver: a RESET byte, the payload bytes, and an
// optional trailing COMMIT byte, with optional idle gaps between bytes.
module correlator_cmd_tx
    import correlator_cmd_pkg::*;
#(
    parameter int SAMPLE_TIME_NIBBLES = 16,
    parameter int ACTIVE_LINE_NIBBLES = 8,
    parameter int GAP_CYCLES          = 0
) (
    input  logic              clk,
    input  logic              reset,
    correlator_cmd_tx_if.slave bus
);

    localparam int                 GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [4:0]         SAMPLE_LAST = 5'(SAMPLE_TIME_NIBBLES - 1);
    localparam logic [4:0]         ACTIVE_LAST = 5'(ACTIVE_LINE_NIBBLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);

    state_e            state, state_d;
    state_e            ret_state, ret_d;
    state_e            follow;
    logic [3:0]        cmd_q;
    logic [63:0]       value_q;
    logic              commit_q;
    logic [4:0]        nib_cnt;
    logic [4:0]        nib_last;
    logic [GAP_W-1:0]  gap_cnt;
    logic              cmd_error_q, error_d;
    logic [7:0]        byte_data_d;
    logic              req_fire, byte_fire;

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.byte_valid = state inside {ST_SEND_RESET, ST_SEND_NIBBLE, ST_SEND_ENABLE, ST_SEND_COMMIT};
    assign bus.byte_data  = byte_data_d;
    assign bus.cmd_error  = cmd_error_q;

    assign req_fire  = bus.req_valid & bus.req_ready;
    assign byte_fire = bus.byte_valid & bus.byte_ready;
    assign nib_last  = (cmd_q == CMD_SET_SAMPLE_TIME) ? SAMPLE_LAST : ACTIVE_LAST;

    // Byte presented in each send state; registers only move on a transfer, so it stays stable while stalled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        byte_data_d = 8'h00;
        case (state)
            ST_SEND_RESET:  byte_data_d = make_byte(cmd_q, CMD_RESET);
            ST_SEND_NIBBLE: byte_data_d = make_byte(value_q[3:0], cmd_q);
            ST_SEND_ENABLE: byte_data_d = make_byte({2'b00, value_q[1:0]}, CMD_ENABLE_MODULES);
            ST_SEND_COMMIT: byte_data_d = make_byte(4'h0, CMD_COMMIT);
            default:        byte_data_d = 8'h00;
        endcase
    end

    // Which byte comes after the current one (IDLE when the sequence is complete).
    always_comb begin
        follow = ST_IDLE;
        case (state)
            ST_SEND_RESET:  follow = (cmd_q == CMD_ENABLE_MODULES) ? ST_SEND_ENABLE : ST_SEND_NIBBLE;
            ST_SEND_NIBBLE: follow = (nib_cnt != nib_last) ? ST_SEND_NIBBLE
                                   : (commit_q ? ST_SEND_COMMIT : ST_IDLE);
            ST_SEND_ENABLE: follow = commit_q ? ST_SEND_COMMIT : ST_IDLE;
            default:        follow = ST_IDLE;
        endcase
    end

    // Next-state logic: start a sequence, step on byte transfers, wait out gaps.
    always_comb begin
        state_d = state;
        ret_d   = ret_state;
        error_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    case (bus.req_cmd)
                        CMD_SET_SAMPLE_TIME,
                        CMD_SET_ACTIVE_LINE,
                        CMD_ENABLE_MODULES: state_d = ST_SEND_RESET;
                        CMD_COMMIT:         state_d = ST_SEND_COMMIT;
                        default:            error_d = 1'b1;
                    endcase
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = ret_state;
            end
            default: begin
                if (byte_fire) begin
                    if (follow != ST_IDLE && GAP_CYCLES != 0) begin
                        state_d = ST_GAP;
                        ret_d   = follow;
                    end else begin
                        state_d = follow;
                    end
                end
            end
        endcase
    end

    // State, captured request and counters; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            cmd_q       <= 4'h0;
            value_q     <= 64'h0;
            commit_q    <= 1'b0;
            nib_cnt     <= 5'd0;
            gap_cnt     <= '0;
            cmd_error_q <= 1'b0;
        end else begin
            state       <= state_d;
            ret_state   <= ret_d;
            cmd_error_q <= error_d;
            if (req_fire) begin
                cmd_q    <= bus.req_cmd;
                value_q  <= bus.req_value;
                commit_q <= bus.req_commit;
                nib_cnt  <= 5'd0;
            end else if (byte_fire && state == ST_SEND_NIBBLE) begin
                value_q <= value_q >> 4;
                nib_cnt <= nib_cnt + 5'd1;
            end
            if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_correlator_cmd_tx.sv
// Self-checking bench: two transmitters (no gap / two-cycle gap) driven from
// one stimulus stream, byte sequences compared against a list model.
module tb_correlator_cmd_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic [3:0]  req_cmd;
    logic [63:0] req_value;
    logic        req_commit;
    logic        byte_ready;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    correlator_cmd_tx_if if_a ();
    correlator_cmd_tx_if if_b ();

    assign if_a.req_valid  = req_valid & ~sel;
    assign if_b.req_valid  = req_valid & sel;
    assign if_a.req_cmd    = req_cmd;
    assign if_b.req_cmd    = req_cmd;
    assign if_a.req_value  = req_value;
    assign if_b.req_value  = req_value;
    assign if_a.req_commit = req_commit;
    assign if_b.req_commit = req_commit;
    assign if_a.byte_ready = byte_ready;
    assign if_b.byte_ready = byte_ready;

    logic       obs_req_ready, obs_byte_valid, obs_busy, obs_cmd_error;
    logic [7:0] obs_byte_data;
    assign obs_req_ready  = sel ? if_b.req_ready  : if_a.req_ready;
    assign obs_byte_valid = sel ? if_b.byte_valid : if_a.byte_valid;
    assign obs_busy       = sel ? if_b.busy       : if_a.busy;
    assign obs_cmd_error  = sel ? if_b.cmd_error  : if_a.cmd_error;
    assign obs_byte_data  = sel ? if_b.byte_data  : if_a.byte_data;

    correlator_cmd_tx #(.SAMPLE_TIME_NIBBLES(16), .ACTIVE_LINE_NIBBLES(8), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    correlator_cmd_tx #(.SAMPLE_TIME_NIBBLES(16), .ACTIVE_LINE_NIBBLES(8), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected byte list for one request, straight from the command rules.
    function automatic void build_expected(input logic [3:0] cmd, input logic [63:0] v, input bit commit);
        int n;
        exp_q.delete();
        case (cmd)
            4'd1, 4'd2: begin
                n = (cmd == 4'd1) ? 16 : 8;
                exp_q.push_back({cmd, 4'h0});
                for (int k = 0; k < n; k++) exp_q.push_back({v[4*k +: 4], cmd});
                if (commit) exp_q.push_back(8'h0D);
            end
            4'd12: begin
                exp_q.push_back(8'hC0);
                exp_q.push_back({2'b00, v[1], v[0], 4'hC});
                if (commit) exp_q.push_back(8'h0D);
            end
            4'd13: exp_q.push_back(8'h0D);
            default: ;
        endcase
    endfunction

    // One request on the selected DUT; mode 0 = ready always, 1 = ready 1-in-3, 2 = random ready.
    task automatic run_req(input string tag, input bit use_b, input logic [3:0] cmd,
                           input logic [63:0] value, input bit commit, input int mode);
        int  gap;
        int  idx;
        int  cycles;
        int  idle_run;
        bit  had_xfer;
        bit  stalled;
        build_expected(cmd, value, commit);
        gap = use_b ? 2 : 0;
        @(negedge clk);
        sel        = use_b;
        byte_ready = 1'b0;
        #1;
        check({tag, " req_ready idle"}, obs_req_ready, 1'b1);
        req_valid  = 1'b1;
        req_cmd    = cmd;
        req_value  = value;
        req_commit = commit;
        @(negedge clk);
        req_valid  = 1'b0;
        req_cmd    = 4'h0;
        req_value  = 64'h0;
        req_commit = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, " err byte_valid"}, obs_byte_valid, 1'b0);
            check({tag, " err pulse"}, obs_cmd_error, 1'b1);
            check({tag, " err busy"}, obs_busy, 1'b0);
            check({tag, " err req_ready"}, obs_req_ready, 1'b1);
            @(negedge clk);
            check({tag, " err pulse end"}, obs_cmd_error, 1'b0);
            check({tag, " err no byte"}, obs_byte_valid, 1'b0);
            return;
        end
        check({tag, " latency"}, obs_byte_valid, 1'b1);
        check({tag, " cmd_error low"}, obs_cmd_error, 1'b0);
        idx = 0; cycles = 0; idle_run = 0; had_xfer = 0; stalled = 0;
        while (idx < exp_q.size() && cycles < 2000) begin
            check($sformatf("%s busy c%0d", tag, cycles), obs_busy, 1'b1);
            if (obs_byte_valid) begin
                check($sformatf("%s byte%0d", tag, idx), obs_byte_data, exp_q[idx]);
                if (had_xfer && !stalled)
                    check($sformatf("%s gap before byte%0d", tag, idx), idle_run, gap);
                idle_run = 0;
                case (mode)
                    0:       byte_ready = 1'b1;
                    1:       byte_ready = (cycles % 3 == 2);
                    default: byte_ready = 1'($urandom_range(0, 1));
                endcase
                if (byte_ready) begin
                    idx++;
                    had_xfer = 1;
                    stalled  = 0;
                end else begin
                    stalled = 1;
                end
            end else begin
                idle_run++;
                byte_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cycles++;
        end
        check({tag, " completed"}, idx, exp_q.size());
        if (mode == 0)
            check({tag, " cycle count"}, cycles, exp_q.size() + (exp_q.size() - 1) * gap);
        byte_ready = 1'b0;
        check({tag, " done busy"}, obs_busy, 1'b0);
        check({tag, " done byte_valid"}, obs_byte_valid, 1'b0);
        check({tag, " done req_ready"}, obs_req_ready, 1'b1);
    endtask

    initial begin
        logic [3:0] cmd_tbl [6] = '{4'd1, 4'd2, 4'd12, 4'd13, 4'd0, 4'd5};
        logic [63:0] v;

        reset      = 1'b1;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_cmd    = 4'h0;
        req_value  = 64'h0;
        req_commit = 1'b0;
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values on both transmitters.
        for (int d = 0; d < 2; d++) begin
            sel = 1'(d);
            #1;
            check($sformatf("reset byte_valid d%0d", d), obs_byte_valid, 1'b0);
            check($sformatf("reset byte_data d%0d", d), obs_byte_data, 8'h00);
            check($sformatf("reset busy d%0d", d), obs_busy, 1'b0);
            check($sformatf("reset cmd_error d%0d", d), obs_cmd_error, 1'b0);
        end
        sel   = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("req_ready after reset", obs_req_ready, 1'b1);

        // Directed sequences.
        run_req("sample_time", 1'b0, 4'd1, 64'h0123_4567_89AB_CDEF, 1'b1, 0);
        run_req("active_line", 1'b0, 4'd2, 64'h0000_0000_8000_0005, 1'b0, 1);
        run_req("enable_gap", 1'b1, 4'd12, 64'h2, 1'b1, 0);
        run_req("bad_cmd7", 1'b0, 4'd7, 64'h0, 1'b1, 0);
        run_req("commit_only", 1'b0, 4'd13, 64'hFFFF, 1'b1, 0);
        run_req("commit_only_gap", 1'b1, 4'd13, 64'h0, 1'b0, 0);
        run_req("sample_gap", 1'b1, 4'd1, 64'hFEDC_BA98_7654_3210, 1'b0, 0);

        // Randomised requests on both transmitters with random back-pressure.
        for (int i = 0; i < 14; i++) begin
            v = {$urandom, $urandom};
            run_req($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                    cmd_tbl[$urandom_range(0, 5)], v, 1'($urandom_range(0, 1)), 2);
        end

        // Reset in the middle of a SET_SAMPLE_TIME sequence, after five bytes.
        v = {$urandom, $urandom};
        build_expected(4'd1, v, 1'b1);
        @(negedge clk);
        sel        = 1'b0;
        req_valid  = 1'b1;
        req_cmd    = 4'd1;
        req_value  = v;
        req_commit = 1'b1;
        byte_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midreset sixth byte", obs_byte_data, exp_q[5]);
        byte_ready = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check("midreset byte_valid", obs_byte_valid, 1'b0);
        check("midreset busy", obs_busy, 1'b0);
        check("midreset byte_data", obs_byte_data, 8'h00);
        reset      = 1'b0;
        byte_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("midreset quiet c%0d", c), obs_byte_valid, 1'b0);
        end
        run_req("after_reset", 1'b0, 4'd2, {$urandom, $urandom}, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
